// File: rtl/usb_pkg.sv
// Shared USB definitions.
//   PID_*            handshake / data PIDs (also used by rc_crc)
//   in_txn_state_t   state encoding of the IN transaction sequencer
package usb_pkg;

    localparam logic [7:0] PID_ACK   = 8'h4B;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_DATA0 = 8'hC3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TOKEN     = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_SEND_ACK  = 3'd3,
        ST_SEND_NAK  = 3'd4,
        ST_DONE      = 3'd5,
        ST_FAIL      = 3'd6
    } in_txn_state_t;

endpackage

// File: rtl/counter.sv
// Generic up-counter with synchronous clear (priority) and count enable.
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear to zero
//   en          increment by one (wraps at 2**WIDTH)
//   count       current value
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/usb_in_txn_fsm.sv
// Next-state and output decode for one USB IN transaction.
//   Inputs : start_in, token_sent, pkt_status, crc_error, rc_hshake, hshake_done,
//            timeout (response timer at its last cycle), retry_last (one failure
//            left), retry_max (failures exhausted)
//   Outputs: registered send_token, send_hshake, hshake_pid, pkt_rec,
//            rc_crcerror, txn_ok, txn_fail, busy and state; combinational
//            counter / payload-latch controls for the top level.
// Handshakes: send_token and send_hshake are levels held until the matching
// done pulse; pkt_rec / rc_crcerror are one-cycle consume pulses answering
// the levels pkt_status / crc_error, which rc_crc holds until consumed.
module usb_in_txn_fsm
    import usb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_in,
    input  logic          token_sent,
    input  logic          pkt_status,
    input  logic          crc_error,
    input  logic [7:0]    rc_hshake,
    input  logic          hshake_done,
    input  logic          timeout,
    input  logic          retry_last,
    input  logic          retry_max,
    output in_txn_state_t state,
    output logic          send_token,
    output logic          send_hshake,
    output logic [7:0]    hshake_pid,
    output logic          pkt_rec,
    output logic          rc_crcerror,
    output logic          txn_ok,
    output logic          txn_fail,
    output logic          busy,
    output logic          cnt_clr,
    output logic          timer_clr,
    output logic          timer_en,
    output logic          retry_inc,
    output logic          data_load
);

    in_txn_state_t next_state;
    logic          consume_pkt;
    logic          consume_crc;

    always_comb begin
        next_state  = state;
        cnt_clr     = 1'b0;
        timer_clr   = 1'b0;
        timer_en    = 1'b0;
        retry_inc   = 1'b0;
        data_load   = 1'b0;
        consume_pkt = 1'b0;
        consume_crc = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_in) begin
                    cnt_clr    = 1'b1;
                    next_state = ST_TOKEN;
                end
            end
            ST_TOKEN: begin
                if (token_sent) begin
                    timer_clr  = 1'b1;
                    next_state = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                timer_en = 1'b1;
                // A CRC error outranks a simultaneous packet; a packet outranks the timeout.
                if (crc_error) begin
                    consume_crc = 1'b1;
                    retry_inc   = 1'b1;
                    next_state  = ST_SEND_NAK;
                end else if (pkt_status) begin
                    consume_pkt = 1'b1;
                    if (rc_hshake == PID_DATA0) begin
                        data_load  = 1'b1;
                        next_state = ST_SEND_ACK;
                    end else if (rc_hshake == PID_NAK) begin
                        retry_inc  = 1'b1;
                        next_state = retry_last ? ST_FAIL : ST_TOKEN;
                    end else begin
                        next_state = ST_FAIL;
                    end
                end else if (timeout) begin
                    retry_inc  = 1'b1;
                    next_state = retry_last ? ST_FAIL : ST_TOKEN;
                end
            end
            ST_SEND_ACK: begin
                if (hshake_done) next_state = ST_DONE;
            end
            ST_SEND_NAK: begin
                // The retry count was already bumped when the CRC error was consumed.
                if (hshake_done) next_state = retry_max ? ST_FAIL : ST_TOKEN;
            end
            ST_DONE:  next_state = ST_IDLE;
            ST_FAIL:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            send_token  <= 1'b0;
            send_hshake <= 1'b0;
            hshake_pid  <= 8'h00;
            pkt_rec     <= 1'b0;
            rc_crcerror <= 1'b0;
            txn_ok      <= 1'b0;
            txn_fail    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= next_state;
            send_token  <= (next_state == ST_TOKEN);
            send_hshake <= (next_state == ST_SEND_ACK) || (next_state == ST_SEND_NAK);
            hshake_pid  <= (next_state == ST_SEND_ACK) ? PID_ACK :
                           (next_state == ST_SEND_NAK) ? PID_NAK : 8'h00;
            pkt_rec     <= consume_pkt;
            rc_crcerror <= consume_crc;
            txn_ok      <= (next_state == ST_DONE);
            txn_fail    <= (next_state == ST_FAIL);
            busy        <= (next_state != ST_IDLE);
        end
    end

endmodule

// File: rtl/usb_in_txn_ctrl.sv
// USB IN transaction controller: requests the IN token, consumes the rc_crc
// result, answers ACK/NAK and retries on NAK, CRC error or response timeout.
//   clk, rst_n                      clock, asynchronous active-low reset
//   start_in                        begin a transaction (ignored while busy)
//   send_token / token_sent         token request level / completion pulse
//   pkt_status, CRC_error           rc_crc result levels
//   rc_hshake, rc_data              received PID and payload
//   pkt_rec, rc_CRCerror            one-cycle consume pulses back to rc_crc
//   send_hshake / hshake_done       handshake request level / completion pulse
//   hshake_pid                      ACK or NAK while send_hshake
//   data_out                        payload latched on DATA0 reception
//   txn_ok, txn_fail                one-cycle transaction result pulses
//   busy                            not idle
//   state                           current sequencer state (debug)
module usb_in_txn_ctrl
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int MAX_RETRY   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_in,
    output logic          send_token,
    input  logic          token_sent,
    input  logic          pkt_status,
    input  logic          CRC_error,
    input  logic [7:0]    rc_hshake,
    input  logic [63:0]   rc_data,
    output logic          pkt_rec,
    output logic          rc_CRCerror,
    output logic          send_hshake,
    output logic [7:0]    hshake_pid,
    input  logic          hshake_done,
    output logic [63:0]   data_out,
    output logic          txn_ok,
    output logic          txn_fail,
    output logic          busy,
    output in_txn_state_t state
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYC);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

    logic [TIMER_W-1:0] timer;
    logic [RETRY_W-1:0] retry;
    logic               cnt_clr;
    logic               timer_clr;
    logic               timer_en;
    logic               retry_inc;
    logic               data_load;

    counter #(.WIDTH(TIMER_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr | timer_clr),
        .en    (timer_en),
        .count (timer)
    );

    // Saturating: the count never moves past MAX_RETRY.
    counter #(.WIDTH(RETRY_W)) u_retry (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (retry_inc && (retry != RETRY_MAX)),
        .count (retry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (data_load) begin
            data_out <= rc_data;
        end
    end

    usb_in_txn_fsm u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_in    (start_in),
        .token_sent  (token_sent),
        .pkt_status  (pkt_status),
        .crc_error   (CRC_error),
        .rc_hshake   (rc_hshake),
        .hshake_done (hshake_done),
        .timeout     (timer == TIMER_LAST),
        .retry_last  (retry == RETRY_LAST),
        .retry_max   (retry == RETRY_MAX),
        .state       (state),
        .send_token  (send_token),
        .send_hshake (send_hshake),
        .hshake_pid  (hshake_pid),
        .pkt_rec     (pkt_rec),
        .rc_crcerror (rc_CRCerror),
        .txn_ok      (txn_ok),
        .txn_fail    (txn_fail),
        .busy        (busy),
        .cnt_clr     (cnt_clr),
        .timer_clr   (timer_clr),
        .timer_en    (timer_en),
        .retry_inc   (retry_inc),
        .data_load   (data_load)
    );

endmodule
